// File: rtl/step_dir_decoder_pkg.sv
// Shared stepper definitions: decoder state set, the generator's period width
// and the direction encoding on drv_dir.
package step_dir_decoder_pkg;

  localparam int PER_W_DEF = 17;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } dec_state_t;

endpackage

// File: rtl/step_edge_filter.sv
// Step edge detector with optional glitch filter (STEP_GLITCH_FILTER_EN).
// Emits a one-cycle rise when MIN_HIGH (or 1) consecutive high samples complete.
module step_edge_filter
  import step_dir_decoder_pkg::*;
#(
  parameter int MIN_HIGH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic drv_step,
  output logic rise
);

`ifdef STEP_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // With a run length of 1 the counter degenerates to the previous-sample flop.
  localparam int RUN_LEN = (FILTER_EN && MIN_HIGH > 1) ? MIN_HIGH : 1;
  localparam int RUN_W   = $clog2(RUN_LEN + 1);

  logic [RUN_W-1:0] high_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      high_run <= '0;
    end else if (!drv_step) begin
      high_run <= '0;
    end else if (high_run != RUN_W'(RUN_LEN)) begin
      high_run <= high_run + RUN_W'(1);
    end
  end

  // Saturation at RUN_LEN blocks a second rise until drv_step is seen low.
  assign rise = drv_step & (high_run == RUN_W'(RUN_LEN - 1));

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: signed position, step period, stall and protocol flags.
// Optional glitch filter on drv_step via STEP_GLITCH_FILTER_EN.
module step_dir_decoder
  import step_dir_decoder_pkg::*;
#(
  parameter int POS_W     = 32,
  parameter int PER_W     = PER_W_DEF,
  parameter int DIR_SETUP = 2,
  parameter int TIMEOUT   = 100000,
  parameter int MIN_HIGH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    drv_enable_SM,
  input  logic                    pos_clr,
  input  logic                    err_clr,
  output logic signed [POS_W-1:0] position,
  output logic        [PER_W-1:0] period,
  output logic                    period_valid,
  output logic                    stall,
  output logic                    dir_err,
  output logic                    dis_step_err,
  output logic                    pos_wrap
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ARMED = ARMED;
  localparam logic [1:0] ST_TRACK = TRACK;

  localparam int AGE_W = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);

  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
    return (&v) ? v : v + PER_W'(1);
  endfunction

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] v);
    return (v >= AGE_W'(DIR_SETUP)) ? AGE_W'(DIR_SETUP) : v + AGE_W'(1);
  endfunction

  // Returns {wrap, next position}; wrap flags the two's-complement rollover.
  function automatic logic [POS_W:0] step_pos(input logic signed [POS_W-1:0] p,
                                              input logic                    dir);
    logic [POS_W:0] r;
    r = '0;
    case (dir)
      DIR_UP:   r = {p == POS_MAX, p + POS_W'(1)};
      DIR_DOWN: r = {p == POS_MIN, p - POS_W'(1)};
    endcase
    return r;
  endfunction

  logic                    rise;
  logic [1:0]              state;
  logic [PER_W-1:0]        cnt;
  logic                    dir_prev;
  logic [AGE_W-1:0]        dir_age;
  logic [AGE_W-1:0]        age_now;
  logic                    dir_short;
  logic                    step_take;
  logic signed [POS_W-1:0] pos_base;
  logic signed [POS_W-1:0] pos_nxt;
  logic                    wrap_nxt;

  step_edge_filter #(
    .MIN_HIGH (MIN_HIGH)
  ) u_edge (
    .clk      (clk),
    .rst      (rst),
    .drv_step (drv_step),
    .rise     (rise)
  );

  // A direction change sampled together with the step counts as age zero.
  assign age_now   = (drv_dir != dir_prev) ? '0 : age_inc(dir_age);
  assign dir_short = (age_now < AGE_W'(DIR_SETUP));
  assign step_take = rise & drv_enable_SM & ((state == ST_ARMED) | (state == ST_TRACK));
  assign pos_base  = pos_clr ? '0 : position;
  assign {wrap_nxt, pos_nxt} = step_pos(pos_base, drv_dir);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      position     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b0;
      dir_err      <= 1'b0;
      dis_step_err <= 1'b0;
      pos_wrap     <= 1'b0;
      dir_prev     <= 1'b0;
      dir_age      <= '0;
    end else begin
      period_valid <= 1'b0;
      stall        <= 1'b0;
      pos_wrap     <= 1'b0;
      dir_prev     <= drv_dir;
      dir_age      <= age_now;
      dir_err      <= (dir_err & ~err_clr) | (step_take & dir_short);
      dis_step_err <= (dis_step_err & ~err_clr) | (rise & ~drv_enable_SM);

      if (step_take) begin
        position <= pos_nxt;
        pos_wrap <= wrap_nxt;
      end else if (pos_clr) begin
        position <= '0;
      end

      if (!drv_enable_SM) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARMED;
          ST_ARMED: begin
            if (rise) begin
              cnt   <= PER_W'(1);
              state <= ST_TRACK;
            end
          end
          ST_TRACK: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              cnt          <= PER_W'(1);
            end else if (cnt == PER_W'(TIMEOUT)) begin
              stall <= 1'b1;
              state <= ST_ARMED;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboard bench for step_dir_decoder: timestamp-based reference model,
// directed plan scenarios followed by randomized step/dir traffic.
module tb_step_dir_decoder;

  localparam int POS_W     = 8;
  localparam int PER_W     = 17;
  localparam int DIR_SETUP = 2;
  localparam int TIMEOUT   = 20;
  localparam int MIN_HIGH  = 3;
`ifdef STEP_GLITCH_FILTER_EN
  localparam int RUN = MIN_HIGH;
`else
  localparam int RUN = 1;
`endif
  localparam int PMAX = 2 ** (POS_W - 1) - 1;
  localparam int PMIN = -(2 ** (POS_W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_step = 1'b0;
  logic drv_dir = 1'b0;
  logic drv_enable_SM = 1'b0;
  logic pos_clr = 1'b0;
  logic err_clr = 1'b0;
  logic signed [POS_W-1:0] position;
  logic [PER_W-1:0] period;
  logic period_valid, stall, dir_err, dis_step_err, pos_wrap;

  step_dir_decoder #(
    .POS_W(POS_W), .PER_W(PER_W), .DIR_SETUP(DIR_SETUP),
    .TIMEOUT(TIMEOUT), .MIN_HIGH(MIN_HIGH)
  ) dut (
    .clk(clk), .rst(rst), .drv_step(drv_step), .drv_dir(drv_dir),
    .drv_enable_SM(drv_enable_SM), .pos_clr(pos_clr), .err_clr(err_clr),
    .position(position), .period(period), .period_valid(period_valid),
    .stall(stall), .dir_err(dir_err), .dis_step_err(dis_step_err),
    .pos_wrap(pos_wrap)
  );

  always #10 clk = ~clk;

  typedef struct {
    int pos;
    int per;
    bit pv;
    bit st;
    bit de;
    bit dse;
    bit wr;
  } snap_t;

  snap_t sq[$];
  int    pq[$];
  int    total = 0;
  int    bad = 0;
  int    pv_cnt = 0;

  // Reference model state: time stamps rather than counters.
  int m_t = 0, m_t_last = 0, m_t_dirchg = 0, m_run = 0, m_pos = 0, m_period = 0;
  bit m_was_en = 0, m_have_ref = 0, m_dir_err = 0, m_dis_err = 0, m_dir_prev = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    int age, nv;
    bit rise, acc, de, dse, pv, st, wr;
    snap_t e;
    m_t++;
    pv = 0; st = 0; wr = 0;
    if (rst) begin
      m_run = 0; m_was_en = 0; m_have_ref = 0; m_pos = 0; m_period = 0;
      m_dir_err = 0; m_dis_err = 0; m_dir_prev = 0; m_t_dirchg = m_t;
    end else begin
      if (drv_dir != m_dir_prev) m_t_dirchg = m_t;
      m_dir_prev = drv_dir;
      age = m_t - m_t_dirchg;
      m_run = drv_step ? m_run + 1 : 0;
      rise = (m_run == RUN);
      acc = rise && drv_enable_SM && m_was_en;
      de = acc && (age < DIR_SETUP);
      dse = rise && !drv_enable_SM;
      if (pos_clr) m_pos = 0;
      if (acc) begin
        nv = m_pos + (drv_dir ? 1 : -1);
        if (nv > PMAX) begin nv -= 2 ** POS_W; wr = 1; end
        else if (nv < PMIN) begin nv += 2 ** POS_W; wr = 1; end
        m_pos = nv;
        if (m_have_ref) begin
          pv = 1;
          m_period = m_t - m_t_last;
          pq.push_back(m_period);
        end
        m_have_ref = 1;
        m_t_last = m_t;
      end else if (m_have_ref && drv_enable_SM && (m_t - m_t_last == TIMEOUT)) begin
        st = 1;
        m_have_ref = 0;
      end
      if (!drv_enable_SM) m_have_ref = 0;
      m_dir_err = (m_dir_err && !err_clr) || de;
      m_dis_err = (m_dis_err && !err_clr) || dse;
      m_was_en = drv_enable_SM;
    end
    e.pos = m_pos; e.per = m_period; e.pv = pv; e.st = st;
    e.de = m_dir_err; e.dse = m_dis_err; e.wr = wr;
    sq.push_back(e);
  endtask

  task automatic cyc(input logic s, input logic d, input logic e,
                     input logic pc, input logic ec, input logic r);
    @(negedge clk);
    drv_step = s; drv_dir = d; drv_enable_SM = e;
    pos_clr = pc; err_clr = ec; rst = r;
    model_edge();
  endtask

  task automatic pulse(input logic d, input int low_cycles);
    repeat (RUN) cyc(1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (low_cycles) cyc(1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: per-cycle snapshot plus period events popped on period_valid.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("position", int'(position), e.pos);
        chk("period", int'(period), e.per);
        chk("period_valid", int'(period_valid), int'(e.pv));
        chk("stall", int'(stall), int'(e.st));
        chk("dir_err", int'(dir_err), int'(e.de));
        chk("dis_step_err", int'(dis_step_err), int'(e.dse));
        chk("pos_wrap", int'(pos_wrap), int'(e.wr));
        if (period_valid) begin
          pv_cnt++;
          if (pq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL period_event: strobe with period %0d, none expected", period);
          end else begin
            chk("period_event", int'(period), pq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bit en_r, dir_r;
    int h, g;
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_position", int'(position), 0);
    chk("reset_period", int'(period), 0);
    chk("reset_flags", int'({dir_err, dis_step_err, stall, pos_wrap, period_valid}), 0);

    // Ten up-steps at a 5-cycle interval.
    repeat (3) cyc(0, 1, 1, 0, 0, 0);
    pv_cnt = 0;
    repeat (10) pulse(1'b1, 5 - RUN);
    cyc(0, 1, 1, 0, 0, 0);
    chk("plan_position", int'(position), 10);
    chk("plan_period", int'(period), 5);
    chk("plan_pv_count", pv_cnt, 9);

    // Steps while disabled, then error clear.
    repeat (3) begin
      repeat (RUN) cyc(1, 1, 0, 0, 0, 0);
      repeat (2) cyc(0, 1, 0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0, 0, 0);
    chk("dis_position", int'(position), 10);
    chk("dis_flag", int'(dis_step_err), 1);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("dis_cleared", int'(dis_step_err), 0);

    // Direction flips one cycle before the accepting sample.
    repeat (3) cyc(0, 1, 1, 0, 0, 0);
    for (int k = 0; k <= RUN; k++) cyc(k > 0, (k >= RUN - 1) ? 1'b0 : 1'b1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("setup_dir_err", int'(dir_err), 1);
    chk("setup_position", int'(position), 9);

    // Count up through the positive limit, then down through the negative one.
    cyc(0, 1, 1, 1, 0, 0);
    repeat (128) pulse(1'b1, 1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("wrap_up_position", int'(position), -128);
    repeat (2) cyc(0, 0, 1, 0, 0, 0);
    pulse(1'b0, 1);
    chk("wrap_down_position", int'(position), 127);

    // Idle past the timeout, then a fresh step.
    repeat (25) cyc(0, 1, 1, 0, 0, 0);
    pulse(1'b1, 3);

    // Clear coinciding with a step; error clear coinciding with a setup error.
    for (int k = 1; k <= RUN; k++) cyc(1, 1, 1, k == RUN, 1, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("clr_then_step", int'(position), 1);
    chk("set_wins", int'(dir_err), 0);
    for (int k = 0; k <= RUN; k++) cyc(k > 0, (k >= RUN - 1) ? 1'b0 : 1'b1, 1, 0, k == RUN, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("set_wins_err", int'(dir_err), 1);

    // Reset in the middle of a pulse train.
    pulse(1'b0, 2);
    repeat (RUN) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("midrst_position", int'(position), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_flags", int'({dir_err, dis_step_err, stall, pos_wrap, period_valid}), 0);

    // Randomized traffic.
    en_r = 1; dir_r = 1;
    for (int b = 0; b < 300; b++) begin
      h = $urandom_range(1, 4);
      g = $urandom_range(1, 24);
      for (int c = 0; c < h + g; c++) begin
        if ($urandom_range(0, 99) < 10) dir_r = ~dir_r;
        if ($urandom_range(0, 99) < (en_r ? 2 : 15)) en_r = ~en_r;
        cyc(c < h, dir_r, en_r, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 4, $urandom_range(0, 999) < 3);
      end
    end

    cyc(0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #5;
    total++;
    if (sq.size() != 0 || pq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d snapshots and %0d periods left, expected 0", sq.size(), pq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_dir_decoder.md
# step_dir_decoder

Receiving end of the stepper-motor step/dir interface driven by the tracking controller and its pulse generator. Samples `drv_step`, `drv_dir` and `drv_enable_SM`, and reconstructs a signed motor position. It measures the step period in clock cycles, in the same units as the generator's `N`. It also flags protocol violations. It serves as the motor-side model in benches and as the position-feedback block in hardware.

## Interface
- `POS_W`, 32, position counter width, signed two's complement.
- `PER_W`, 17, period width; matches the generator's `N`.
- `DIR_SETUP`, 2, minimum number of cycles `drv_dir` must be stable before an accepted step edge.
- `TIMEOUT`, 100000, idle cycles in TRACK before a stall is declared; must be less than 2^PER_W.
- `MIN_HIGH`, 3, filter length in samples; used only with the filter macro.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `drv_step`  in  1  step pulse; the rising edge is the step event.
- `drv_dir`  in  1  direction: 1 counts up, 0 counts down.
- `drv_enable_SM`  in  1  driver enable.
- `pos_clr`  in  1  synchronous position clear.
- `err_clr`  in  1  clears the sticky error flags.
- `position`  out  POS_W  accumulated signed step count.
- `period`  out  PER_W  last measured edge-to-edge period.
- `period_valid`  out  1  one-cycle strobe when `period` updates.
- `stall`  out  1  one-cycle strobe on TRACK timeout.
- `dir_err`  out  1  sticky: direction changed within `DIR_SETUP` cycles of an accepted edge.
- `dis_step_err`  out  1  sticky: step edge seen while disabled.
- `pos_wrap`  out  1  one-cycle strobe when `position` wraps.

## Operation
- Reset values: `position` = 0, `period` = 0, all strobes and flags = 0, `state` = IDLE, `step_prev` = 0, `dir_age` = 0, `cnt` = 0.
- Edge detection:
  - rise = `drv_step` & ~`step_prev`; `step_prev` is the registered previous sample.
  - `dir_age` counts cycles since `drv_dir` last changed and saturates at `DIR_SETUP`.
- States:
  - IDLE: `drv_enable_SM` = 0. A rise is not counted and sets `dis_step_err`. When enable is 1, go to ARMED.
  - ARMED: the first rise counts a step, loads `cnt` = 1, and goes to TRACK. No period is produced.
  - TRACK: `cnt` increments every cycle and saturates at 2^PER_W−1.
    - On a rise: `period` <= `cnt`, `period_valid` = 1, `cnt` <= 1, and a step is counted.
    - If `cnt` reaches `TIMEOUT`: `stall` = 1, go to ARMED.
  - From any state, enable = 0 goes to IDLE with `cnt` <= 0. This takes priority over a simultaneous rise, which then sets `dis_step_err`.
- Step count: `position` += 1 if `drv_dir` = 1, else −1. Wraps modulo 2^POS_W; a wrap pulses `pos_wrap`.
- An accepted rise with `dir_age` < `DIR_SETUP` still counts using the sampled `drv_dir`, and sets `dir_err`.
- `pos_clr` with a simultaneous rise: `position` <= ±1. The clear happens first, then the step.
- `err_clr` with a simultaneous error event: the flag stays set. Set wins.
- `rst` mid-operation returns every register to its reset value on that edge.

## Timing
- Latency without the filter: `position`, `period`, `period_valid` and `pos_wrap` update on the same edge that first samples `drv_step` high, and are visible after that edge.
- Latency with the filter: the update edge is the one on which `MIN_HIGH` consecutive high samples complete.
- Rise interval 5 cycles gives `period` = 5. Minimum accepted interval is 2 cycles (high/low alternating).
- `stall` fires `TIMEOUT` cycles after the last accepted rise.
- The `period` value persists until the next measurement.

## Configuration
- `STEP_GLITCH_FILTER_EN` defined:
  - A rise is accepted only after `drv_step` is sampled high for `MIN_HIGH` consecutive cycles.
  - A subsequent rise needs `drv_step` sampled low first.
  - Shorter pulses are dropped silently.
  - Latency grows by `MIN_HIGH`−1 cycles.
- Not defined: no filter; every 0→1 sample transition is an edge, and `MIN_HIGH` is ignored.

## Structure
- The shared stepper package holds:
  - the state enum (IDLE, ARMED, TRACK)
  - the `PER_W` default of 17, shared with the pulse generator's `N`
  - the dir encoding constants (UP = 1, DOWN = 0)
- One sub-module, `step_edge_filter`: edge detector plus the optional glitch filter. It outputs a single-cycle `rise`.

## Test plan
- Enable = 1, dir = 1, 10 step pulses with a 5-cycle period → `position` = 10, `period` = 5, and 9 `period_valid` strobes (the first edge gives none).
- Steps while enable = 0 → `position` unchanged, `dis_step_err` = 1. `err_clr` → flag back to 0.
- Dir toggled 1 cycle before a rise, `DIR_SETUP` = 2 → `dir_err` = 1, and `position` moves by the sampled direction.
- `position` = 2^31−1, one up-step → `position` = −2^31, `pos_wrap` strobe.
- `TIMEOUT` = 20, no rise for 20 cycles after the last rise → `stall` strobe, state ARMED. The next rise produces no period.
- Filter defined, `MIN_HIGH` = 3: a 2-cycle pulse → ignored; a 3-cycle pulse → counted 2 cycles after the first high sample. `rst` mid-stream → all outputs 0.
